// File: rtl/pulse_filter_nch.sv
// Multi-channel pulse/debounce filter.
// Each raw input is synchronised, then a per-channel counter must see the
// new level for thr+1 consecutive cycles before the registered output
// follows it. Accepted changes raise one-cycle rise/fall strobes and a
// sticky change flag; the masked flags are ORed into a registered irq.
// No valid/ready handshake: every output is a plain registered level or
// one-cycle strobe, valid on every clock.
module pulse_filter_nch #(
    parameter int CH    = 32,
    parameter int CNT_W = 22
) (
    input  logic             clk_20m,
    input  logic             rst,
    input  logic [CH-1:0]    pulse_in,
    input  logic [CH-1:0]    ch_en,
    input  logic             bypass,
    input  logic [CNT_W-1:0] rise_cfg,
    input  logic [CNT_W-1:0] fall_cfg,
    input  logic [CH-1:0]    chg_clr,
    input  logic [CH-1:0]    irq_en,
    output logic [CH-1:0]    pulse_out,
    output logic [CH-1:0]    rise_pulse,
    output logic [CH-1:0]    fall_pulse,
    output logic [CH-1:0]    chg_flag,
    output logic             irq
);

    logic [CH-1:0]    s1_q;
    logic [CH-1:0]    s2_q;
    logic [CNT_W-1:0] cnt_q [CH];
    logic [CNT_W-1:0] cnt_d [CH];
    logic [CH-1:0]    out_q;
    logic [CH-1:0]    out_d;
    logic [CH-1:0]    rise_q;
    logic [CH-1:0]    rise_d;
    logic [CH-1:0]    fall_q;
    logic [CH-1:0]    fall_d;
    logic [CH-1:0]    flag_q;
    logic [CH-1:0]    flag_d;
    logic [CH-1:0]    accept;
    logic             irq_q;
    logic             irq_d;

    // Two-flop synchroniser on every raw input; nothing else sees pulse_in.
    always_ff @(posedge clk_20m) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= pulse_in;
            s2_q <= s1_q;
        end
    end

    // Per-channel filter decision, events, sticky flags and irq next state.
    // The counter only runs while the synchronised level differs from the
    // output and the count is below the live threshold, so it cannot wrap.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            cnt_d[i]  = '0;
            out_d[i]  = out_q[i];
            accept[i] = 1'b0;
            if (ch_en[i]) begin
                if (bypass) begin
                    out_d[i]  = s2_q[i];
                    accept[i] = (s2_q[i] != out_q[i]);
                end else if (s2_q[i] != out_q[i]) begin
                    if (cnt_q[i] >= (s2_q[i] ? rise_cfg : fall_cfg)) begin
                        out_d[i]  = s2_q[i];
                        accept[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
            end
        end
        rise_d = accept & s2_q;
        fall_d = accept & ~s2_q;
        // A set on the same edge as a clear wins.
        flag_d = (flag_q & ~chg_clr) | accept;
        irq_d  = |(flag_q & irq_en);
    end

    // Filter state, strobes, flags and irq registers.
    always_ff @(posedge clk_20m) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                cnt_q[i] <= '0;
            end
            out_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            flag_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            flag_q <= flag_d;
            irq_q  <= irq_d;
        end
    end

    assign pulse_out  = out_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign chg_flag   = flag_q;
    assign irq        = irq_q;

endmodule

// File: doc/pulse_filter_nch.md
PULSE_FILTER_NCH -- requirements
Module: pulse_filter_nch

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; clock port clk_20m, reset port rst.
REQ-002 Parameter CH, default 32, SHALL set the number of independent input channels (1..64).
REQ-003 Parameter CNT_W, default 22, SHALL set the width of each channel's counter and of both filter configs (4,000,000 cycles is 200 ms at 20 MHz).
REQ-004 clk_20m  in  1  20 MHz system clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 pulse_in  in  CH  raw asynchronous inputs.
REQ-007 ch_en  in  CH  per-channel filter enable.
REQ-008 bypass  in  1  global bypass: output follows the synchronised input.
REQ-009 rise_cfg  in  CNT_W  threshold for a 0->1 transition.
REQ-010 fall_cfg  in  CNT_W  threshold for a 1->0 transition.
REQ-011 chg_clr  in  CH  write-1-to-clear strobe for chg_flag.
REQ-012 irq_en  in  CH  per-channel interrupt mask.
REQ-013 pulse_out  out  CH  filtered stable value, registered.
REQ-014 rise_pulse  out  CH  one-cycle strobe on an accepted 0->1 change.
REQ-015 fall_pulse  out  CH  one-cycle strobe on an accepted 1->0 change.
REQ-016 chg_flag  out  CH  sticky change-detected flags.
REQ-017 irq  out  1  registered OR of (chg_flag & irq_en).

Function
REQ-018 Each pulse_in bit SHALL pass through a 2-flop synchroniser (s1, s2) before any other use.
REQ-019 Per channel, when ch_en=1, bypass=0 and s2 != pulse_out: if cnt >= thr, pulse_out <= s2 and cnt <= 0; otherwise cnt <= cnt+1. thr is rise_cfg when s2=1 and fall_cfg when s2=0.
REQ-020 When s2 == pulse_out, the channel's cnt SHALL be cleared to 0 on the same edge; any glitch therefore restarts filtering from zero.
REQ-021 A change SHALL be accepted only after thr+1 consecutive mismatching cycles at s2; thr=0 accepts after 1 cycle.
REQ-022 Latency SHALL be thr+3 clk_20m edges, counted from the edge that first captures the new level into s1, to the pulse_out change.
REQ-023 Comparison SHALL use the current cfg value every cycle; if cfg is lowered below a running cnt, the change SHALL be accepted on the next mismatching edge.
REQ-024 cnt SHALL never wrap; the >= compare guarantees acceptance before all-ones; cfg = 2^CNT_W-1 is legal.
REQ-025 When ch_en=0, the channel SHALL hold pulse_out, force cnt to 0 and generate no events; on re-enable, filtering SHALL restart from cnt=0.
REQ-026 When bypass=1 and ch_en=1, pulse_out SHALL load s2 every cycle, cnt SHALL be held at 0, and events SHALL still be generated.
REQ-027 rise_pulse/fall_pulse SHALL assert high for exactly one cycle, on the same edge pulse_out changes.
REQ-028 chg_flag[i] SHALL set on any accepted change and clear when chg_clr[i]=1; a set and a clear on the same edge SHALL leave it set.
REQ-029 irq SHALL update one cycle after chg_flag/irq_en change.
REQ-030 Channels SHALL be fully independent; simultaneous events on all CH channels SHALL all be captured.

Reset
REQ-031 While rst=1 at an edge, s1, s2, cnt, pulse_out, rise_pulse, fall_pulse, chg_flag and irq SHALL all load 0, overriding all other inputs.
REQ-032 Reset asserted mid-count SHALL discard the count; an input held high through reset SHALL be re-filtered from 0 and produce a rise event.

Verification
REQ-033 rise_cfg=4, ch0 high for 4 cycles then low -> pulse_out[0] stays 0, no rise_pulse, chg_flag[0]=0.
REQ-034 rise_cfg=4, ch0 high held -> pulse_out[0]=1 at edge 7 after s1 capture, rise_pulse[0] for 1 cycle, chg_flag[0]=1; with irq_en[0]=1, irq=1 one cycle later.
REQ-035 rise_cfg=2, fall_cfg=10, ch3 toggle 1 then 0 -> rise accepted after 3 mismatch cycles, fall after 11.
REQ-036 chg_clr[5] pulsed on the same edge as a new ch5 change -> chg_flag[5] stays 1; a later lone chg_clr[5] -> 0 and irq drops.
REQ-037 cnt at 100 with fall_cfg changed from 1000 to 50 -> change accepted on the next edge; ch_en=0 mid-count -> pulse_out holds and cnt=0.
REQ-038 rst=1 pulsed for one cycle during an active count with all pulse_in high -> all outputs 0, then every channel rises after rise_cfg+3 edges.
